// File: rtl/branch_redirect_unit.sv
// Next-PC unit: owns the fetch PC, a direct-mapped BTB with 2-bit direction counters,
// resolves EX branches/jumps into flush/redirect and keeps saturating statistics.
module branch_redirect_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     BTB_ENTRIES = 64,
   parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
   parameter logic [1:0]      CTR_INIT    = 2'b01
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            ex_valid_i,
   input  logic            ex_branch_i,
   input  logic            ex_jump_i,
   input  logic            ex_cond_true_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_target_i,
   input  logic            ex_pred_taken_i,
   input  logic [XLEN-1:0] ex_pred_target_i,
   output logic            flush_o,
   output logic [31:0]     branch_cnt_o,
   output logic [31:0]     mispred_cnt_o
);

   localparam int unsigned     IDXW    = $clog2(BTB_ENTRIES);
   localparam int unsigned     TAGW    = XLEN - IDXW - 2;
   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

   logic [XLEN-1:0] pc_r;
   logic [31:0]     br_cnt_r;
   logic [31:0]     mp_cnt_r;
   logic            valid_r [BTB_ENTRIES];
   logic [TAGW-1:0] tag_r   [BTB_ENTRIES];
   logic [XLEN-1:0] tgt_r   [BTB_ENTRIES];
   logic [1:0]      ctr_r   [BTB_ENTRIES];

   logic [IDXW-1:0] lk_idx_s;
   logic [TAGW-1:0] lk_tag_s;
   logic            lk_hit_s;
   logic            pred_taken_s;
   logic [XLEN-1:0] pred_target_s;
   logic [IDXW-1:0] ex_idx_s;
   logic [TAGW-1:0] ex_tag_s;
   logic            ex_hit_s;
   logic            res_s;
   logic            taken_s;
   logic            mispred_s;
   logic [XLEN-1:0] next_pc_s;

   // Fetch-side BTB lookup on the current PC (sees pre-update contents).
   always_comb begin
      lk_idx_s     = pc_r[IDXW+1:2];
      lk_tag_s     = pc_r[XLEN-1:IDXW+2];
      lk_hit_s     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
      pred_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];
      if (pred_taken_s) begin
         pred_target_s = tgt_r[lk_idx_s];
      end else begin
         pred_target_s = pc_r + PC_STEP;
      end
   end

   // EX resolution: actual direction versus the prediction carried down the pipe.
   always_comb begin
      ex_idx_s  = ex_pc_i[IDXW+1:2];
      ex_tag_s  = ex_pc_i[XLEN-1:IDXW+2];
      ex_hit_s  = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
      res_s     = ex_valid_i && (ex_branch_i || ex_jump_i);
      taken_s   = ex_jump_i || (ex_branch_i && ex_cond_true_i);
      mispred_s = res_s && ((taken_s != ex_pred_taken_i) ||
                            (taken_s && (ex_target_i != ex_pred_target_i)));
   end

   // Next fetch PC: a redirect overrides a hazard stall.
   always_comb begin
      if (mispred_s) begin
         if (taken_s) begin
            next_pc_s = ex_target_i;
         end else begin
            next_pc_s = ex_pc_i + PC_STEP;
         end
      end else if (stall_i) begin
         next_pc_s = pc_r;
      end else begin
         next_pc_s = pred_target_s;
      end
   end

   // Fetch PC and saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r     <= RESET_PC;
         br_cnt_r <= 32'h0000_0000;
         mp_cnt_r <= 32'h0000_0000;
      end else begin
         pc_r <= next_pc_s;
         if (res_s && (br_cnt_r != CNT_MAX)) begin
            br_cnt_r <= br_cnt_r + 32'd1;
         end
         if (mispred_s && (mp_cnt_r != CNT_MAX)) begin
            mp_cnt_r <= mp_cnt_r + 32'd1;
         end
      end
   end

   // BTB training from resolved EX instructions; untaken misses leave the table alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_r[i] <= 1'b0;
            ctr_r[i]   <= CTR_INIT;
         end
      end else if (res_s) begin
         if (ex_hit_s) begin
            if (taken_s) begin
               tgt_r[ex_idx_s] <= ex_target_i;
               if (ctr_r[ex_idx_s] != 2'b11) begin
                  ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] + 2'b01;
               end
            end else if (ctr_r[ex_idx_s] != 2'b00) begin
               ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] - 2'b01;
            end
         end else if (taken_s) begin
            valid_r[ex_idx_s] <= 1'b1;
            tag_r[ex_idx_s]   <= ex_tag_s;
            tgt_r[ex_idx_s]   <= ex_target_i;
            ctr_r[ex_idx_s]   <= 2'b10;
         end
      end
   end

   assign pc_o          = pc_r;
   assign pred_taken_o  = pred_taken_s;
   assign pred_target_o = pred_target_s;
   assign flush_o       = mispred_s && !rst;
   assign branch_cnt_o  = br_cnt_r;
   assign mispred_cnt_o = mp_cnt_r;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: hand-computed PC, prediction, flush,
// BTB-entry and statistics expectations at the default parameters.
module tb_branch_redirect_unit;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic [31:0] pc_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        ex_valid_i;
   logic        ex_branch_i;
   logic        ex_jump_i;
   logic        ex_cond_true_i;
   logic [31:0] ex_pc_i;
   logic [31:0] ex_target_i;
   logic        ex_pred_taken_i;
   logic [31:0] ex_pred_target_i;
   logic        flush_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispred_cnt_o;

   int total_s;
   int bad_s;

   branch_redirect_unit dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .pc_o             (pc_o),
      .pred_taken_o     (pred_taken_o),
      .pred_target_o    (pred_target_o),
      .ex_valid_i       (ex_valid_i),
      .ex_branch_i      (ex_branch_i),
      .ex_jump_i        (ex_jump_i),
      .ex_cond_true_i   (ex_cond_true_i),
      .ex_pc_i          (ex_pc_i),
      .ex_target_i      (ex_target_i),
      .ex_pred_taken_i  (ex_pred_taken_i),
      .ex_pred_target_i (ex_pred_target_i),
      .flush_o          (flush_o),
      .branch_cnt_o     (branch_cnt_o),
      .mispred_cnt_o    (mispred_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_s++;
      if (got !== exp) begin
         bad_s++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_idle();
      ex_valid_i       = 1'b0;
      ex_branch_i      = 1'b0;
      ex_jump_i        = 1'b0;
      ex_cond_true_i   = 1'b0;
      ex_pc_i          = 32'h0;
      ex_target_i      = 32'h0;
      ex_pred_taken_i  = 1'b0;
      ex_pred_target_i = 32'h0;
   endtask

   task automatic ex_set(input logic br, input logic jp, input logic cond,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
      ex_valid_i       = 1'b1;
      ex_branch_i      = br;
      ex_jump_i        = jp;
      ex_cond_true_i   = cond;
      ex_pc_i          = pc;
      ex_target_i      = tgt;
      ex_pred_taken_i  = ptk;
      ex_pred_target_i = ptgt;
   endtask

   initial begin
      total_s = 0;
      bad_s   = 0;
      rst     = 1'b1;
      stall_i = 1'b0;
      ex_idle();

      // reset, with a mispredicting jump in EX that must be ignored
      tick();
      ex_set(1'b0, 1'b1, 1'b0, 32'h10, 32'h40, 1'b0, 32'h14);
      #1;
      chk("rst_flush", {31'd0, flush_o}, 32'd0);
      tick();
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_pred", {31'd0, pred_taken_o}, 32'd0);
      chk("rst_br", branch_cnt_o, 32'd0);
      chk("rst_mp", mispred_cnt_o, 32'd0);
      rst = 1'b0;
      ex_idle();
      tick();
      chk("seq_4", pc_o, 32'h4);
      tick();
      chk("seq_8", pc_o, 32'h8);
      tick();
      chk("seq_c", pc_o, 32'hC);
      tick();
      chk("seq_10", pc_o, 32'h10);
      chk("cold_pred", {31'd0, pred_taken_o}, 32'd0);
      chk("cold_tgt", pred_target_o, 32'h14);

      // cold taken branch @0x10 -> 0x40
      ex_set(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b0, 32'h14);
      #1;
      chk("cold_flush", {31'd0, flush_o}, 32'd1);
      tick();
      ex_idle();
      chk("cold_pc", pc_o, 32'h40);
      chk("cold_mp", mispred_cnt_o, 32'd1);
      chk("cold_br", branch_cnt_o, 32'd1);
      chk("cold_ctr", {30'd0, dut.ctr_r[4]}, 32'd2);
      ex_set(1'b0, 1'b1, 1'b0, 32'h3C, 32'h10, 1'b0, 32'h40);
      tick();
      ex_idle();
      chk("refetch_pc", pc_o, 32'h10);
      chk("refetch_pred", {31'd0, pred_taken_o}, 32'd1);
      chk("refetch_tgt", pred_target_o, 32'h40);

      // loop branch @0x20 -> 0x18: taken x3, then not taken
      ex_set(1'b1, 1'b0, 1'b1, 32'h20, 32'h18, 1'b0, 32'h24);
      tick();
      chk("loop1_pc", pc_o, 32'h18);
      ex_set(1'b1, 1'b0, 1'b1, 32'h20, 32'h18, 1'b1, 32'h18);
      #1;
      chk("loop2_flush", {31'd0, flush_o}, 32'd0);
      tick();
      chk("loop2_pc", pc_o, 32'h1C);
      chk("loop2_ctr", {30'd0, dut.ctr_r[8]}, 32'd3);
      tick();
      chk("loop3_pc", pc_o, 32'h20);
      chk("loop3_ctr", {30'd0, dut.ctr_r[8]}, 32'd3);
      ex_idle();
      #1;
      chk("loop_pred", {31'd0, pred_taken_o}, 32'd1);
      chk("loop_ptgt", pred_target_o, 32'h18);
      ex_set(1'b1, 1'b0, 1'b0, 32'h20, 32'h18, 1'b1, 32'h18);
      #1;
      chk("loop4_flush", {31'd0, flush_o}, 32'd1);
      tick();
      ex_idle();
      chk("loop4_pc", pc_o, 32'h24);
      chk("loop4_ctr", {30'd0, dut.ctr_r[8]}, 32'd2);
      chk("loop_br", branch_cnt_o, 32'd6);
      chk("loop_mp", mispred_cnt_o, 32'd4);

      // stall versus redirect, then stall alone
      stall_i = 1'b1;
      ex_set(1'b0, 1'b1, 1'b0, 32'h50, 32'h80, 1'b0, 32'h54);
      #1;
      chk("stall_flush", {31'd0, flush_o}, 32'd1);
      tick();
      ex_idle();
      chk("stall_redir", pc_o, 32'h80);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", pc_o, 32'h80);
      end
      stall_i = 1'b0;
      chk("stall_br", branch_cnt_o, 32'd7);

      // aliasing 0x110 onto 0x10's entry
      ex_set(1'b1, 1'b0, 1'b1, 32'h110, 32'h200, 1'b0, 32'h114);
      tick();
      chk("alias_pc", pc_o, 32'h200);
      ex_set(1'b0, 1'b1, 1'b0, 32'h300, 32'h10, 1'b0, 32'h304);
      tick();
      ex_idle();
      chk("alias_pc2", pc_o, 32'h10);
      chk("alias_pred", {31'd0, pred_taken_o}, 32'd0);
      chk("alias_ptgt", pred_target_o, 32'h14);

      // JALR target change on a predicted-taken jump
      ex_set(1'b0, 1'b1, 1'b0, 32'h3C, 32'h90, 1'b1, 32'h10);
      #1;
      chk("jalr_flush", {31'd0, flush_o}, 32'd1);
      tick();
      chk("jalr_pc", pc_o, 32'h90);
      chk("jalr_tgt", dut.tgt_r[15], 32'h90);
      ex_set(1'b0, 1'b1, 1'b0, 32'h8C, 32'h3C, 1'b0, 32'h90);
      tick();
      ex_idle();
      chk("jalr_fetch", pc_o, 32'h3C);
      chk("jalr_pred", {31'd0, pred_taken_o}, 32'd1);
      chk("jalr_ptgt", pred_target_o, 32'h90);
      chk("jalr_mp", mispred_cnt_o, 32'd9);

      // top of address space wraps
      ex_set(1'b0, 1'b1, 1'b0, 32'h94, 32'hFFFF_FFFC, 1'b0, 32'h98);
      tick();
      ex_idle();
      chk("top_pc", pc_o, 32'hFFFF_FFFC);
      chk("top_pred", {31'd0, pred_taken_o}, 32'd0);
      chk("top_ptgt", pred_target_o, 32'h0);
      tick();
      chk("wrap_pc", pc_o, 32'h0);

      // untaken miss: no allocation, no flush
      ex_set(1'b1, 1'b0, 1'b0, 32'h44, 32'h80, 1'b0, 32'h48);
      #1;
      chk("nt_flush", {31'd0, flush_o}, 32'd0);
      tick();
      ex_idle();
      chk("nt_valid", {31'd0, dut.valid_r[17]}, 32'd0);
      chk("nt_br", branch_cnt_o, 32'd13);
      chk("nt_mp", mispred_cnt_o, 32'd10);

      // not-taken mispredict at the top: ex_pc+4 wraps
      ex_set(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h100, 1'b1, 32'h100);
      tick();
      ex_idle();
      chk("ntwrap_pc", pc_o, 32'h0);

      // statistics saturation
      force dut.br_cnt_r = 32'hFFFF_FFFE;
      force dut.mp_cnt_r = 32'hFFFF_FFFE;
      #1;
      release dut.br_cnt_r;
      release dut.mp_cnt_r;
      ex_set(1'b0, 1'b1, 1'b0, 32'h40, 32'h100, 1'b0, 32'h44);
      tick();
      chk("sat1_br", branch_cnt_o, 32'hFFFF_FFFF);
      chk("sat1_mp", mispred_cnt_o, 32'hFFFF_FFFF);
      tick();
      chk("sat2_br", branch_cnt_o, 32'hFFFF_FFFF);
      chk("sat2_mp", mispred_cnt_o, 32'hFFFF_FFFF);

      // reset mid-stream with a mispredict in EX
      rst = 1'b1;
      #1;
      chk("mid_flush", {31'd0, flush_o}, 32'd0);
      tick();
      ex_idle();
      chk("mid_pc", pc_o, 32'h0);
      chk("mid_br", branch_cnt_o, 32'd0);
      chk("mid_mp", mispred_cnt_o, 32'd0);
      rst = 1'b0;
      tick();
      chk("mid_seq", pc_o, 32'h4);

      $display("test done: total=%0d bad=%0d", total_s, bad_s);
      $finish;
   end

endmodule
